// File: rtl/gen_preset_timer.sv
// Preset-duration down-counter: selects a per-phase duration from (state, specific),
// loads it on pulse and counts down on tick with hold/pause, restart and optional auto-reload.
module gen_preset_timer #(
  parameter int WIDTH       = 6,
  parameter int PRESET_E    = 30,
  parameter int PRESET_A    = 15,
  parameter int PRESET_A_SP = 22,
  parameter int PRESET_G    = 30,
  parameter int PRESET_L    = 5,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pulse,
  input  logic [1:0]       state,
  input  logic             specific,
  input  logic             tick,
  input  logic             hold,
  output logic [WIDTH-1:0] preset,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } fsm_e;

  localparam logic [WIDTH-1:0] P_E    = WIDTH'(PRESET_E);
  localparam logic [WIDTH-1:0] P_A    = WIDTH'(PRESET_A);
  localparam logic [WIDTH-1:0] P_A_SP = WIDTH'(PRESET_A_SP);
  localparam logic [WIDTH-1:0] P_G    = WIDTH'(PRESET_G);
  localparam logic [WIDTH-1:0] P_L    = WIDTH'(PRESET_L);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO   = '0;

  fsm_e             fsm_q;
  logic [WIDTH-1:0] count_q;
  logic             busy_q;
  logic             done_q;
  logic             inhibit;

  // G with specific set has no duration; loads are refused in that phase
  assign inhibit = (state == 2'b10) && specific;

  always_comb begin
    preset = ZERO;
    case (state)
      2'b00:   preset = P_E;
      2'b01:   preset = specific ? P_A_SP : P_A;
      2'b10:   preset = specific ? ZERO : P_G;
      default: preset = P_L;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q   <= IDLE;
      count_q <= ZERO;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (pulse && !inhibit) begin
        count_q <= preset;
        if (preset == ZERO) begin
          fsm_q  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else begin
          fsm_q  <= RUN;
          busy_q <= 1'b1;
        end
      end else begin
        case (fsm_q)
          RUN: begin
            if (hold) begin
              fsm_q <= PAUSE;
            end else if (tick) begin
              if (count_q > ONE) begin
                count_q <= count_q - ONE;
              end else begin
                done_q <= 1'b1;
                // Reload only when the current phase actually has a duration
                if (AUTO_RELOAD && !inhibit && (preset != ZERO)) begin
                  count_q <= preset;
                end else begin
                  count_q <= ZERO;
                  fsm_q   <= IDLE;
                  busy_q  <= 1'b0;
                end
              end
            end
          end
          PAUSE: begin
            if (!hold) fsm_q <= RUN;
          end
          default: ;
        endcase
      end
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_gen_preset_timer.sv
// Directed bench for gen_preset_timer: default build plus a 4-bit auto-reload build.
module tb_gen_preset_timer;

  logic       clk = 1'b0;
  logic       reset, pulse, specific, tick, hold;
  logic [1:0] state;

  logic [5:0] preset0, count0;
  logic       busy0, done0;
  logic [3:0] preset1, count1;
  logic       busy1, done1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gen_preset_timer u0 (
    .clk(clk), .reset(reset), .pulse(pulse), .state(state), .specific(specific),
    .tick(tick), .hold(hold), .preset(preset0), .count(count0), .busy(busy0), .done(done0)
  );

  gen_preset_timer #(.WIDTH(4), .AUTO_RELOAD(1'b1)) u1 (
    .clk(clk), .reset(reset), .pulse(pulse), .state(state), .specific(specific),
    .tick(tick), .hold(hold), .preset(preset1), .count(count1), .busy(busy1), .done(done1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [1:0] st, input logic sp);
    state = st; specific = sp; pulse = 1'b1;
    step();
    pulse = 1'b0;
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    repeat (n) step();
    tick = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pulse = 1'b0; state = 2'b00; specific = 1'b0; tick = 1'b0; hold = 1'b0;
    step(); step();
    reset = 1'b0;
    chk("rst_count", count0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);

    // L countdown with spaced ticks
    state = 2'b11;
    #1 chk("preset_L", preset0, 5);
    load(2'b11, 1'b0);
    chk("load_L_count", count0, 5);
    chk("load_L_busy", busy0, 1);
    for (int i = 1; i <= 5; i++) begin
      step(); step();
      tick = 1'b1;
      step();
      tick = 1'b0;
      chk("L_count", count0, 5 - i);
      chk("L_done", done0, (i == 5) ? 1 : 0);
      chk("L_busy", busy0, (i == 5) ? 0 : 1);
    end
    step();
    chk("L_done_single", done0, 0);

    // Preset table
    state = 2'b01; specific = 1'b0; #1 chk("preset_A", preset0, 15);
    specific = 1'b1; #1 chk("preset_A_sp", preset0, 22);
    state = 2'b00; specific = 1'b0; #1 chk("preset_E", preset0, 30);
    state = 2'b10; #1 chk("preset_G", preset0, 30);
    specific = 1'b1; #1 chk("preset_G_inh", preset0, 0);
    state = 2'b00; #1 chk("preset_E_trunc_w4", preset1, 14);
    state = 2'b01; specific = 1'b1; #1 chk("preset_Asp_trunc_w4", preset1, 6);

    // Inhibited pulse during a run is ignored
    load(2'b11, 1'b0);
    ticks(1);
    load(2'b10, 1'b1);
    chk("inh_count", count0, 4);
    chk("inh_busy", busy0, 1);
    chk("inh_done", done0, 0);

    // Hold freezes countdown, ticks in pause discarded
    load(2'b00, 1'b0);
    chk("E_load", count0, 30);
    ticks(10);
    chk("E_10ticks", count0, 20);
    hold = 1'b1;
    ticks(20);
    chk("hold_count", count0, 20);
    chk("hold_busy", busy0, 1);
    chk("hold_done", done0, 0);
    hold = 1'b0;
    step();
    chk("release_count", count0, 20);
    ticks(1);
    chk("resume_count", count0, 19);

    // Restart coincident with tick: load wins, tick dropped
    load(2'b11, 1'b0);
    ticks(2);
    chk("restart_pre", count0, 3);
    state = 2'b01; specific = 1'b0; pulse = 1'b1; tick = 1'b1;
    step();
    pulse = 1'b0; tick = 1'b0;
    chk("restart_count", count0, 15);
    chk("restart_busy", busy0, 1);

    // Auto-reload build
    load(2'b11, 1'b0);
    chk("ar_load", count1, 5);
    ticks(4);
    chk("ar_4ticks", count1, 1);
    ticks(1);
    chk("ar_reload_count", count1, 5);
    chk("ar_reload_done", done1, 1);
    chk("ar_reload_busy", busy1, 1);
    step();
    chk("ar_done_single", done1, 0);
    state = 2'b10; specific = 1'b1;
    ticks(4);
    chk("ar_inh_pre", count1, 1);
    ticks(1);
    chk("ar_inh_count", count1, 0);
    chk("ar_inh_busy", busy1, 0);
    chk("ar_inh_done", done1, 1);

    // Reset mid-run dominates pulse and tick
    load(2'b01, 1'b0);
    ticks(3);
    chk("mid_count", count0, 12);
    reset = 1'b1; pulse = 1'b1; tick = 1'b1;
    step();
    reset = 1'b0; pulse = 1'b0; tick = 1'b0;
    chk("mid_rst_count", count0, 0);
    chk("mid_rst_busy", busy0, 0);
    chk("mid_rst_done", done0, 0);
    ticks(2);
    chk("idle_ticks_ignored", count0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gen_preset_timer.md
Name: gen_preset_timer

Overview:
Parametrised successor to the combinational preset generator. It selects a per-phase duration from the (state, specific) pair and loads it into a down-counter on a load strobe. The counter then counts down on a time-base tick and flags expiry to the phase-sequencing FSM. Presets, counter width and auto-reload are configurable, and the block adds pause/hold and a mid-run restart.

Parameters:
WIDTH, 6, counter and preset width in bits
PRESET_E, 30, duration for state E (any specific)
PRESET_A, 15, duration for state A, specific=0
PRESET_A_SP, 22, duration for state A, specific=1
PRESET_G, 30, duration for state G, specific=0
PRESET_L, 5, duration for state L (any specific)
AUTO_RELOAD, 0, 1 = reload the preset on expiry and keep running

Ports:
clk  in  1  system clock; all state changes on the rising edge
reset  in  1  synchronous, active-high reset
pulse  in  1  load strobe, sampled each clk edge
state  in  2  phase code: 00=E, 01=A, 10=G, 11=L
specific  in  1  mode qualifier for A/G
tick  in  1  time-base enable, one-cycle strobe per time unit
hold  in  1  freeze countdown while high
preset  out  WIDTH  combinational preset for the current state/specific; 0 when inhibited
count  out  WIDTH  remaining time units
busy  out  1  high while in RUN or PAUSE
done  out  1  one-cycle expiry pulse

Behaviour:
- Preset select (combinational):
  - E → PRESET_E.
  - A → PRESET_A or PRESET_A_SP, chosen by specific.
  - G with specific=0 → PRESET_G.
  - G with specific=1 → inhibited: preset=0.
  - L → PRESET_L.
  - Parameter values are truncated modulo 2^WIDTH.
- Reset: FSM=IDLE, count=0, busy=0, done=0. Reset dominates pulse, tick and hold in the same cycle.
- FSM states are IDLE, RUN and PAUSE. busy=1 in RUN and PAUSE.
- Load (any FSM state): pulse=1 and not inhibited → count<=preset at that edge, FSM→RUN, done=0.
  - A load during RUN or PAUSE restarts the countdown. Any pending pause is cleared.
  - pulse while inhibited (G, specific=1) is ignored: no change to count or FSM.
  - A load with preset==0 (non-inhibited, parameter 0) → count=0, FSM→IDLE, done=1 on the next cycle.
- RUN:
  - tick=1, hold=0, count>1 → count decrements by 1.
  - tick=1, hold=0, count==1 → count<=0 and done=1 for exactly one cycle. With AUTO_RELOAD=0 the FSM goes to IDLE.
  - hold=1 → FSM→PAUSE and count is frozen. A tick in the same cycle is discarded.
- PAUSE: count is frozen and ticks are ignored. hold=0 → FSM→RUN, and counting resumes on the next tick.
- Priority when events coincide: reset > pulse > hold > tick. A pulse and tick in the same cycle load the preset, and that tick is not applied.
- AUTO_RELOAD=1: on the expiry edge, count<=preset of the current inputs and the FSM stays in RUN. done still pulses for one cycle. If the current inputs are inhibited, the FSM goes to IDLE with count=0.
- Latency:
  - Load is visible on count one cycle after pulse.
  - For preset P, done rises on the edge that consumes the P-th qualified tick.
- IDLE: count holds its value (0 after expiry). Ticks are ignored and done=0.
- Counting never wraps: count never goes below 0.

Test Plan:
- Reset, then state=L, pulse for 1 cycle, then 5 ticks spaced 3 cycles apart → count reads 5,4,3,2,1,0; done high for exactly 1 cycle on the 5th tick; busy falls on the same edge.
- state=A: specific=0 → preset=15; specific=1 → preset=22. state=G, specific=1, pulse → preset=0, count and busy unchanged, no done.
- Load E (30), 10 ticks, then hold=1 for 20 cycles with ticks → count stays at 20. Release hold → next tick gives 19.
- Load L, 2 ticks (count=3), then pulse with state=A, specific=0 in the same cycle as a tick → count=15 and the tick is ignored.
- AUTO_RELOAD=1, WIDTH=4, state=L: after 5 ticks → done pulse and count reloads to 5 with busy staying 1. Switch to G/specific=1 before the next expiry → at expiry the FSM goes to IDLE with count=0.
- Assert reset mid-run (count=12) coincident with pulse and tick → count=0, busy=0, done=0 on the next cycle.
